// File: rtl/lshift16_arbiter.sv
// Two-requester arbiter sharing one 16-bit barrel left shifter.
// Ports: clk, rst (async, active-high); req0/req1 valid/ready/a/shl
// requester handshakes; res_valid/res_ready/res_data/res_id output
// slot; busy mirrors res_valid; op_count counts consumed results.

// Log-depth barrel left shifter with zero fill; purely combinational.
// Ports: a (operand), shl (shift amount 0..15), y (a << shl).
module Lshift16_gen (
    input  logic [15:0] a,
    input  logic [3:0]  shl,
    output logic [15:0] y
);
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] s4;

    always_comb begin
        s1 = shl[0] ? {a[14:0], 1'b0} : a;
        s2 = shl[1] ? {s1[13:0], 2'b0} : s1;
        s4 = shl[2] ? {s2[11:0], 4'b0} : s2;
        y  = shl[3] ? {s4[7:0], 8'b0} : s4;
    end
endmodule

module lshift16_arbiter #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_a,
    input  logic [3:0]       req0_shl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_a,
    input  logic [3:0]       req1_shl,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        last_gnt;
    logic        sel;
    logic        can_accept;
    logic        accept;
    logic        consume;
    logic [15:0] sh_a;
    logic [3:0]  sh_amt;
    logic [15:0] sh_y;

    assign res_valid = (state_q == FULL);
    assign busy      = res_valid;
    assign consume   = res_valid && res_ready;

    // A full slot can still accept when it drains in the same cycle,
    // which gives back-to-back issue without a bubble.
    assign can_accept = !rst && (!res_valid || res_ready);

    // Requester select; only meaningful when at least one is valid.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = (RR_EN != 0) ? ~last_gnt : 1'b0;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready = can_accept && req0_valid && !sel;
    assign req1_ready = can_accept && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;

    assign sh_a   = sel ? req1_a : req0_a;
    assign sh_amt = sel ? req1_shl : req0_shl;

    Lshift16_gen u_shift (
        .a   (sh_a),
        .shl (sh_amt),
        .y   (sh_y)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (res_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload and grant history only move on accept, so a stalled or
    // drained slot keeps its last result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= 16'h0000;
            res_id   <= 1'b0;
            last_gnt <= 1'b1;
        end else if (accept) begin
            res_data <= sh_y;
            res_id   <= sel;
            last_gnt <= sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (consume) begin
            op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_lshift16_arbiter.sv
// Self-checking bench for lshift16_arbiter: table vectors, directed
// sequences and random traffic checked against a behavioural model.
module tb_lshift16_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0v;
    logic [15:0] r0a;
    logic [3:0]  r0s;
    logic        r1v;
    logic [15:0] r1a;
    logic [3:0]  r1s;
    logic        rr;
    logic        req0_ready;
    logic        req1_ready;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_id;
    logic        busy;
    logic [7:0]  op_count;

    logic        f0v;
    logic        f1v;
    logic        f_req0_ready;
    logic        f_req1_ready;
    logic        f_res_valid;
    logic [15:0] f_res_data;
    logic        f_res_id;
    logic        f_busy;
    logic [7:0]  f_op_count;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    lshift16_arbiter #(.RR_EN(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(req0_ready),
        .req0_a(r0a), .req0_shl(r0s),
        .req1_valid(r1v), .req1_ready(req1_ready),
        .req1_a(r1a), .req1_shl(r1s),
        .res_valid(res_valid), .res_ready(rr),
        .res_data(res_data), .res_id(res_id),
        .busy(busy), .op_count(op_count)
    );

    lshift16_arbiter #(.RR_EN(0), .CNT_W(8)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(f0v), .req0_ready(f_req0_ready),
        .req0_a(16'h0003), .req0_shl(4'd2),
        .req1_valid(f1v), .req1_ready(f_req1_ready),
        .req1_a(16'h0005), .req1_shl(4'd1),
        .res_valid(f_res_valid), .res_ready(1'b1),
        .res_data(f_res_data), .res_id(f_res_id),
        .busy(f_busy), .op_count(f_op_count)
    );

    // Behavioural model: one-entry slot plus a history of grants.
    bit          m_full;
    logic [15:0] m_data;
    bit          m_id;
    int          m_cnt;
    bit          grants[$];
    bit          e0;
    bit          e1;

    function automatic logic [15:0] ref_shl(logic [15:0] a, logic [3:0] s);
        logic [31:0] p;
        p = {16'h0, a} * (32'd1 << s);
        return p[15:0];
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_data = 16'h0;
        m_id   = 0;
        m_cnt  = 0;
        grants.delete();
    endtask

    task automatic model_ready();
        bit can;
        bit last;
        bit win;
        last = (grants.size() == 0) ? 1'b1 : grants[grants.size()-1];
        can  = !rst && (!m_full || rr);
        if (r0v && r1v) win = !last;
        else            win = r1v;
        e0 = can && r0v && !win;
        e1 = can && r1v && win;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the
    // next negedge.
    task automatic tick();
        bit cons;
        #1;
        if (rst) model_reset();
        model_ready();
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("res_valid", res_valid, m_full);
        chk("busy", busy, m_full);
        chk("res_data", res_data, m_data);
        chk("res_id", res_id, m_id);
        chk("op_count", op_count, 32'(m_cnt % 256));
        @(posedge clk);
        if (!rst) begin
            cons = m_full && rr;
            if (e0 || e1) begin
                m_data = e1 ? ref_shl(r1a, r1s) : ref_shl(r0a, r0s);
                m_id   = e1;
                m_full = 1;
                grants.push_back(e1);
            end else if (cons) begin
                m_full = 0;
            end
            if (cons) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0v = 0;
        r1v = 0;
        f0v = 0;
        f1v = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [3:0]  s;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{16'hFFFF, 4'd0, 16'hFFFF};
        vt[1] = '{16'hFFFF, 4'd15, 16'h8000};
        vt[2] = '{16'h0001, 4'd15, 16'h8000};
        vt[3] = '{16'h8000, 4'd1, 16'h0000};
        vt[4] = '{16'h00F1, 4'd4, 16'h0F10};
        vt[5] = '{16'h1234, 4'd8, 16'h3400};

        rst = 1'b1;
        r0v = 0; r0a = 0; r0s = 0;
        r1v = 0; r1a = 0; r1s = 0;
        rr  = 1'b1;
        f0v = 0; f1v = 0;
        @(negedge clk);
        do_reset();
        chk("reset_res_valid", res_valid, 0);
        chk("reset_op_count", op_count, 0);

        // Single request
        r0v = 1; r0a = 16'h00F1; r0s = 4'd4; rr = 1;
        #1 chk("t1_ready", req0_ready, 1);
        tick();
        r0v = 0;
        #1;
        chk("t1_valid", res_valid, 1);
        chk("t1_data", res_data, 16'h0F10);
        chk("t1_id", res_id, 0);
        tick();
        #1 chk("t1_count", op_count, 1);

        // Boundary shift table
        foreach (vt[i]) begin
            r0v = 1; r0a = vt[i].a; r0s = vt[i].s;
            tick();
            r0v = 0;
            #1 chk("shift_tbl", res_data, vt[i].exp);
            tick();
        end

        // Contention: round-robin vs fixed priority
        do_reset();
        r0v = 1; r0a = 16'h0011; r0s = 4'd1;
        r1v = 1; r1a = 16'h0022; r1s = 4'd2;
        f0v = 1; f1v = 1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("fp_no_req1", f_req1_ready, 0);
            tick();
            #1;
            chk("rr_valid", res_valid, 1);
            chk("rr_seq", res_id, k % 2);
            chk("fp_seq", f_res_id, 0);
            chk("fp_data", f_res_data, 16'h000C);
        end
        r0v = 0; r1v = 0; f0v = 0; f1v = 0;
        tick();

        // Backpressure
        do_reset();
        r0v = 1; r0a = 16'h1234; r0s = 4'd8; rr = 0;
        tick();
        r0v = 0;
        r1v = 1; r1a = 16'h5555; r1s = 4'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_r1", req1_ready, 0);
            chk("bp_data", res_data, 16'h3400);
            tick();
        end
        rr = 1;
        #1 chk("bp_release", req1_ready, 1);
        tick();
        r1v = 0;
        #1;
        chk("bp_reload", res_data, 16'hAAAA);
        chk("bp_id", res_id, 1);
        tick();

        // Asynchronous reset mid-operation
        r0v = 1; r0a = 16'h0F0F; r0s = 4'd3; rr = 0;
        tick();
        r0v = 0;
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", res_valid, 0);
        chk("ar_data", res_data, 0);
        chk("ar_count", op_count, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        r0v = 1; r1v = 1; rr = 1;
        #1;
        chk("ar_gnt0", req0_ready, 1);
        chk("ar_gnt1", req1_ready, 0);
        tick();
        r0v = 0; r1v = 0;
        tick();

        // Counter wrap
        do_reset();
        rr = 1;
        for (int k = 0; k < 300 && m_cnt < 256; k++) begin
            r0v = 1; r0a = 16'(k); r0s = 4'(k);
            tick();
        end
        r0v = 0;
        chk("wrap_reached", m_cnt, 256);
        #1 chk("wrap_count", op_count, 0);
        tick();

        // Random traffic
        r0v = 0; r1v = 0; e0 = 0; e1 = 0;
        for (int k = 0; k < 500; k++) begin
            if (!r0v || e0) begin
                r0v = 1'($urandom_range(0, 1));
                r0a = 16'($urandom);
                r0s = 4'($urandom_range(0, 15));
            end
            if (!r1v || e1) begin
                r1v = 1'($urandom_range(0, 1));
                r1a = 16'($urandom);
                r1s = 4'($urandom_range(0, 15));
            end
            rr = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lshift16_arbiter.md
Name: lshift16_arbiter

Overview:
- Shares a single 16-bit combinational barrel left shifter (Lshift16_gen) between two requesters.
- Each requester uses a valid/ready handshake. Grants are round-robin, or fixed-priority when configured.
- The shift result is registered into a one-entry output slot with its own valid/ready handshake, tagged with the requester ID.
- Sits between ALU-side issue logic and writeback.

Parameters:
- RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.
- CNT_W, default 8: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  16  requester 0 operand.
- req0_shl  in  4  requester 0 shift amount, 0..15.
- req1_valid, req1_ready, req1_a, req1_shl: same as requester 0, for requester 1.
- res_valid  out  1  output slot holds a result.
- res_ready  in  1  consumer takes the result this cycle.
- res_data  out  16  registered result, equal to A << shl with zero fill.
- res_id  out  1  ID of the requester that produced res_data.
- busy  out  1  equals res_valid; for debug and power gating.
- op_count  out  CNT_W  number of results consumed, modulo 2^CNT_W.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high: port rst, clock clk.
  - While rst=1: res_valid=0, res_data=0, res_id=0, op_count=0, last_gnt=1 (so requester 0 has priority on the first contention).
  - reqX_ready outputs are combinational and are 0 while rst=1.
- Slot states: EMPTY (res_valid=0) and FULL (res_valid=1).
- can_accept = EMPTY or (FULL and res_ready). This allows back-to-back issue with no bubble.
- Arbitration (combinational):
  - Only one valid: that requester is selected.
  - Both valid, RR_EN=1: select the requester that is not last_gnt.
  - Both valid, RR_EN=0: select requester 0.
  - reqX_ready = can_accept and reqX_valid and (selected == X). At most one ready is high per cycle.
- Accept cycle N (some reqX_valid and reqX_ready both high):
  - The shifter is driven by the selected operand and shift amount.
  - At the edge ending cycle N: res_data <= shifted value, res_id <= X, res_valid <= 1, last_gnt <= X.
  - Latency: result is visible in cycle N+1. Throughput: 1 operation per cycle.
- Consume (res_valid and res_ready):
  - op_count increments and wraps at 2^CNT_W.
  - If no new accept happens in the same cycle, res_valid <= 0. res_data and res_id hold their stale values.
- Consume and accept in the same cycle: the slot reloads with the new result, res_valid stays 1, and op_count increments.
- Stall (FULL and res_ready=0):
  - Both readies are 0.
  - res_data and res_id are held stable.
  - last_gnt does not change.
- Requester obligation: hold valid, a and shl stable until ready. Inputs while valid=0 are ignored.
- Arithmetic:
  - shl=0 passes A through.
  - shl=15 gives {A[0], 15'b0}.
  - Bits shifted past bit 15 are discarded. No carry or overflow flag.
- Starvation bound (RR_EN=1): with both requesters continuously valid and a non-stalling consumer, grants alternate strictly, so each requester waits at most 1 accept.
- Reset mid-operation: a pending result is dropped with no output, op_count clears, and any in-flight handshake is aborted. Requesters must re-present the operation.

Test Plan:
1. Single request: req0 a=16'h00F1, shl=4, res_ready=1 → req0_ready=1 in the same cycle; next cycle res_valid=1, res_data=16'h0F10, res_id=0; op_count=1 after consume.
2. Boundary shifts: a=16'hFFFF with shl=0 → 16'hFFFF; shl=15 → 16'h8000; a=16'h0001, shl=15 → 16'h8000; a=16'h8000, shl=1 → 16'h0000.
3. Contention, RR_EN=1: both valid for 4 accepts, res_ready=1 → res_id sequence 0,1,0,1, one result per cycle with no bubbles. With RR_EN=0 → sequence 0,0,0,0 and req1_ready never asserts.
4. Backpressure: fill the slot (a=16'h1234, shl=8 → 16'h3400), hold res_ready=0 for 3 cycles with req1 valid → both readies 0, res_data stable at 16'h3400; raise res_ready → req1 accepted in that same cycle, with the slot reloaded on the next edge.
5. Async reset mid-operation: assert rst between clock edges while res_valid=1 → res_valid, res_data and op_count go to 0 immediately; after release, a contended first grant goes to req0.
6. Counter wrap (CNT_W=8): 256 consumed results → op_count returns to 0.
